matmul_bus_master: RTL and testbench
====================================

Name: matmul_bus_master

Overview:
- Bus initiator that drives the matrix-multiply register-file slave through one complete job.
- Sequence: write operand A rows, write operand B rows, write the control word with the start bit set, poll control until start clears, read result rows from a scratchpad target, read flags.
- Sits between a host-side stream interface and the accelerator's register bus.

Parameters:
- DATA_WIDTH, 32, element width in bits.
- BUS_WIDTH, 64, register bus data width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam), ROW_W = $clog2(MAX_DIM).
- ADDR_WIDTH, 32, bus address width.
- POLL_GAP, 4, idle cycles between consecutive control polls (>=1).
- POLL_LIMIT, 1024, max polls before timeout (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset (one clock, synchronous active-high reset; fixed)
- cmd_valid_i  in  1  job request
- cmd_ready_o  out  1  high only in IDLE
- cmd_ctrl_i  in  16  control word to program; bit0 (start) forced to 1 by this block
- cmd_target_i  in  2  scratchpad target to read back (SP0..SP3)
- in_valid_i / in_ready_o  in/out  1/1  operand row stream handshake
- in_data_i  in  BUS_WIDTH  operand row: MAX_DIM rows of A, then MAX_DIM rows of B
- address_o  out  ADDR_WIDTH  bus address
- data_o  out  BUS_WIDTH  bus write data
- write_enable_o  out  1  write strobe, one cycle per write
- strobe_o  out  MAX_DIM  element byte-lane strobe; all ones on operand writes, 0 otherwise
- sp_read_o  out  1  high while issuing scratchpad/flags reads
- data_i  in  BUS_WIDTH  bus read data
- out_valid_o / out_ready_i  out/in  1/1  result row handshake
- out_data_o  out  BUS_WIDTH  result row
- flags_o  out  BUS_WIDTH  flags captured at end of job
- done_o  out  1  one-cycle pulse at job end
- error_o  out  1  timeout flag, held until next accepted command

Behaviour:
- Reset (synchronous, rst_i=1 at edge): state IDLE. All outputs 0 except cmd_ready_o=1. Any job in flight is abandoned; bus signals go low at that edge.
- Address map, bits [4:0]: CONTROL 0x00, OPERAND_A 0x04, OPERAND_B 0x08, FLAGS 0x0C, SP0..SP3 0x10/0x14/0x18/0x1C. Row index at address_o[5 +: ROW_W]. All other address bits 0.
- Write: address_o/data_o/strobe_o valid with write_enable_o=1 for exactly one cycle.
- Read: address_o held for 2 cycles with write_enable_o=0; data_i sampled at the end of the 2nd cycle.
- IDLE: on cmd_valid_i && cmd_ready_o, latch ctrl and target, clear error_o, row counter=0, go to WR_A.
- WR_A / WR_B:
  - in_ready_o=1. Each accepted beat produces a write to 0x04 (or 0x08) at row=counter, strobe all ones.
  - At most one beat per cycle.
  - After MAX_DIM beats: WR_A goes to WR_B (counter reset); WR_B goes to WR_CTRL.
  - in_valid_i low inserts idle cycles; no bus activity during them.
- WR_CTRL: one write to 0x00, data = {zeros, ctrl[15:1], 1'b1}, strobe 0. Go to POLL_WAIT.
- POLL_WAIT: count POLL_GAP cycles, then POLL_RD (2-cycle read of 0x00).
  - Sampled bit0=1: back to POLL_WAIT.
  - Sampled bit0=0: go to RD_SP, counter=0.
- RD_SP:
  - 2-cycle read of 0x10 + 4*target at row=counter, with sp_read_o=1. Load out_data_o, assert out_valid_o, go to OUT.
- OUT: hold out_valid_o and out_data_o stable until out_ready_i.
  - On handshake: counter+1; go to RD_SP, or to RD_FLAGS after MAX_DIM rows.
  - Handshake in the same cycle the data loads is impossible (out_valid_o rises first).
- RD_FLAGS: 2-cycle read of 0x0C with sp_read_o=1. Latch flags_o, pulse done_o, go to IDLE.
- Counters are ROW_W+1 bits; no wrap occurs within a job.
- cmd_valid_i outside IDLE is ignored. in_valid_i outside WR_A/WR_B is ignored (in_ready_o=0).

Optional Feature:
- Macro: MATMUL_BUS_MASTER_TIMEOUT_EN.
- Defined: a poll counter increments per POLL_RD. When POLL_LIMIT polls all read start=1, set error_o=1, pulse done_o, skip RD_SP/RD_FLAGS, return to IDLE. flags_o is unchanged.
- Undefined: polling continues indefinitely; error_o is tied 0.

Test Plan:
- Basic job (MAX_DIM=2): A rows 0x00000002_00000001, 0x00000004_00000003; B identity; ctrl 0x0000; target 0. Required:
  - writes to 0x04/row0, 0x04/row1 (0x24), 0x08/row0, 0x08/row1.
  - then 0x00 with data 0x1.
  - slave clears start after 3 polls; out rows equal the slave SP0 rows; done_o pulses once.
- Stream gaps: in_valid_i toggling every other cycle gives exactly 4 operand writes with no duplicates; write_enable_o is never high without a prior handshake.
- Output backpressure: out_ready_i low for 10 cycles gives out_data_o stable and no further bus reads until the handshake.
- Target select: cmd_target_i=3 gives reads at 0x1C and 0x3C; flags read at 0x0C latches 0xA5 into flags_o.
- Reset mid-job: rst_i=1 in POLL_WAIT. Next cycle: IDLE, cmd_ready_o=1, all bus outputs 0; a new job then completes normally.
- With MATMUL_BUS_MASTER_TIMEOUT_EN, POLL_LIMIT=8, start never clears: exactly 8 control reads, then error_o=1, done_o pulse, no SP reads.

Source files
------------

// File: rtl/matmul_bus_master.sv
// Bus initiator that runs one matrix-multiply job on the accelerator register file.
// Optional poll timeout: define MATMUL_BUS_MASTER_TIMEOUT_EN.
module matmul_bus_master #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int POLL_GAP   = 4,
   parameter int POLL_LIMIT = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic [15:0]                       cmd_ctrl_i,
   input  logic [1:0]                        cmd_target_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [BUS_WIDTH-1:0]              in_data_i,
   output logic [ADDR_WIDTH-1:0]             address_o,
   output logic [BUS_WIDTH-1:0]              data_o,
   output logic                              write_enable_o,
   output logic [BUS_WIDTH/DATA_WIDTH-1:0]   strobe_o,
   output logic                              sp_read_o,
   input  logic [BUS_WIDTH-1:0]              data_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [BUS_WIDTH-1:0]              out_data_o,
   output logic [BUS_WIDTH-1:0]              flags_o,
   output logic                              done_o,
   output logic                              error_o
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int ROW_W   = $clog2(MAX_DIM);
   localparam int CW      = ROW_W + 1;
   localparam int GW      = $clog2(POLL_GAP + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_A, S_WR_B, S_WR_CTRL, S_POLL_WAIT, S_POLL_RD, S_RD_SP, S_OUT, S_RD_FLAGS
   } state_t;

   state_t                    r_state, w_next;
   logic [CW-1:0]             r_cnt;
   logic [GW-1:0]             r_gap;
   logic                      r_phase;
   logic [15:0]               r_ctrl;
   logic [1:0]                r_target;
   logic                      r_we;
   logic [ADDR_WIDTH-1:0]     r_waddr;
   logic [BUS_WIDTH-1:0]      r_wdata;
   logic [MAX_DIM-1:0]        r_strb;
   logic [BUS_WIDTH-1:0]      r_out_data;
   logic [BUS_WIDTH-1:0]      r_flags;
   logic                      r_done;
   logic                      w_last;
   logic                      w_is_rd;
   logic                      w_timeout;
   logic [ADDR_WIDTH-1:0]     w_rd_addr;

   function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [4:0] off, input logic [CW-1:0] row);
      logic [ADDR_WIDTH-1:0] a;
      a = '0;
      a[4:0] = off;
      a[5 +: ROW_W] = row[ROW_W-1:0];
      return a;
   endfunction

   assign w_last  = (r_cnt == CW'(MAX_DIM - 1));
   assign w_is_rd = (r_state == S_POLL_RD) || (r_state == S_RD_SP) || (r_state == S_RD_FLAGS);

`ifdef MATMUL_BUS_MASTER_TIMEOUT_EN
   localparam int PW = $clog2(POLL_LIMIT + 1);
   logic [PW-1:0] r_polls;
   logic          r_error;
   assign w_timeout = (r_polls == PW'(POLL_LIMIT - 1));
   assign error_o   = r_error;
`else
   // Polling never gives up here, so POLL_LIMIT has no effect on this build.
   assign w_timeout = 1'b0 & (POLL_LIMIT == 0);
   assign error_o   = 1'b0;
`endif

   always_comb begin
      w_rd_addr = '0;
      case (r_state)
         S_RD_SP:    w_rd_addr = mk_addr({1'b1, r_target, 2'b00}, r_cnt);
         S_RD_FLAGS: w_rd_addr = mk_addr(5'h0C, '0);
         default:    w_rd_addr = '0;
      endcase
   end

   // Bus writes are registered one cycle after acceptance; reads never overlap them.
   assign address_o      = r_we ? r_waddr : w_rd_addr;
   assign data_o         = r_wdata;
   assign write_enable_o = r_we;
   assign strobe_o       = r_strb;
   assign sp_read_o      = (r_state == S_RD_SP) || (r_state == S_RD_FLAGS);
   assign cmd_ready_o    = (r_state == S_IDLE);
   assign in_ready_o     = (r_state == S_WR_A) || (r_state == S_WR_B);
   assign out_valid_o    = (r_state == S_OUT);
   assign out_data_o     = r_out_data;
   assign flags_o        = r_flags;
   assign done_o         = r_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (cmd_valid_i) w_next = S_WR_A;
         S_WR_A:      if (in_valid_i && w_last) w_next = S_WR_B;
         S_WR_B:      if (in_valid_i && w_last) w_next = S_WR_CTRL;
         S_WR_CTRL:   w_next = S_POLL_WAIT;
         S_POLL_WAIT: if (r_gap == GW'(POLL_GAP - 1)) w_next = S_POLL_RD;
         S_POLL_RD: begin
            if (r_phase) begin
               if (!data_i[0])     w_next = S_RD_SP;
               else if (w_timeout) w_next = S_IDLE;
               else                w_next = S_POLL_WAIT;
            end
         end
         S_RD_SP:     if (r_phase) w_next = S_OUT;
         S_OUT:       if (out_ready_i) w_next = w_last ? S_RD_FLAGS : S_RD_SP;
         S_RD_FLAGS:  if (r_phase) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_gap      <= '0;
         r_phase    <= 1'b0;
         r_ctrl     <= '0;
         r_target   <= '0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_strb     <= '0;
         r_out_data <= '0;
         r_flags    <= '0;
         r_done     <= 1'b0;
`ifdef MATMUL_BUS_MASTER_TIMEOUT_EN
         r_polls    <= '0;
         r_error    <= 1'b0;
`endif
      end else begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_done  <= 1'b0;
         r_phase <= w_is_rd ? ~r_phase : 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  r_ctrl   <= cmd_ctrl_i;
                  r_target <= cmd_target_i;
                  r_cnt    <= '0;
`ifdef MATMUL_BUS_MASTER_TIMEOUT_EN
                  r_error  <= 1'b0;
`endif
               end
            end
            S_WR_A, S_WR_B: begin
               if (in_valid_i) begin
                  r_we    <= 1'b1;
                  r_waddr <= mk_addr((r_state == S_WR_A) ? 5'h04 : 5'h08, r_cnt);
                  r_wdata <= in_data_i;
                  r_strb  <= '1;
                  r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
               end
            end
            S_WR_CTRL: begin
               r_we    <= 1'b1;
               r_waddr <= '0;
               r_wdata <= BUS_WIDTH'(r_ctrl | 16'h0001);
               r_gap   <= '0;
`ifdef MATMUL_BUS_MASTER_TIMEOUT_EN
               r_polls <= '0;
`endif
            end
            S_POLL_WAIT: r_gap <= (r_gap == GW'(POLL_GAP - 1)) ? '0 : r_gap + 1'b1;
            S_POLL_RD: begin
               if (r_phase) begin
`ifdef MATMUL_BUS_MASTER_TIMEOUT_EN
                  r_polls <= r_polls + 1'b1;
                  if (data_i[0] && w_timeout) begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                  end
`endif
                  if (!data_i[0]) r_cnt <= '0;
               end
            end
            S_RD_SP:  if (r_phase) r_out_data <= data_i;
            S_OUT:    if (out_ready_i) r_cnt <= r_cnt + 1'b1;
            S_RD_FLAGS: begin
               if (r_phase) begin
                  r_flags <= data_i;
                  r_done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_bus_master.sv
// Bench for matmul_bus_master: table of jobs against a small register-file slave model,
// plus hand-written reset-mid-job and (with MATMUL_BUS_MASTER_TIMEOUT_EN) timeout sequences.
module tb_matmul_bus_master;
   localparam int BW = 64;
   localparam int AW = 32;
   localparam int PG = 4;
   localparam int PL = 8;
   localparam int PERIOD = PG + 2;
   localparam int NJOBS = 4;

   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic           cmd_valid_i = 1'b0;
   logic           cmd_ready_o;
   logic [15:0]    cmd_ctrl_i = '0;
   logic [1:0]     cmd_target_i = '0;
   logic           in_valid_i = 1'b0;
   logic           in_ready_o;
   logic [BW-1:0]  in_data_i = '0;
   logic [AW-1:0]  address_o;
   logic [BW-1:0]  data_o;
   logic           write_enable_o;
   logic [1:0]     strobe_o;
   logic           sp_read_o;
   logic [BW-1:0]  data_i;
   logic           out_valid_o;
   logic           out_ready_i = 1'b0;
   logic [BW-1:0]  out_data_o;
   logic [BW-1:0]  flags_o;
   logic           done_o;
   logic           error_o;

   always #5 clk = ~clk;

   matmul_bus_master #(
      .DATA_WIDTH(32), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .POLL_GAP(PG), .POLL_LIMIT(PL)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_ctrl_i(cmd_ctrl_i), .cmd_target_i(cmd_target_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .address_o(address_o), .data_o(data_o), .write_enable_o(write_enable_o),
      .strobe_o(strobe_o), .sp_read_o(sp_read_o), .data_i(data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .flags_o(flags_o), .done_o(done_o), .error_o(error_o)
   );

   typedef struct {
      logic [1:0][BW-1:0] a;
      logic [1:0][BW-1:0] b;
      logic [15:0]        ctrl;
      logic [1:0]         target;
      logic [BW-1:0]      flags;
      int                 hold;
      bit                 gaps;
      int                 bp;
      logic [BW-1:0]      exp_ctrl;
      logic [AW-1:0]      exp_rd_base;
   } job_t;

   job_t jobs[NJOBS];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int ctrl_cyc = 0;
   int first_sp_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   bit sp_seen = 1'b0;

   logic [AW+BW+1:0] exp_wr_q[$];
   logic [AW-1:0]    exp_rd_q[$];
   logic [BW-1:0]    exp_out_q[$];

   // Slave model: start bit stays set for hold_cyc poll periods after the control write.
   int            hold_cyc = 0;
   int            s_cnt = 1000000;
   logic [BW-1:0] flags_val = '0;
   logic [7:0]    job_tag = '0;

   function automatic logic [BW-1:0] sp_row(input logic [1:0] t, input logic r);
      return {16'hC0DE, job_tag, 6'd0, t, 31'd0, r};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (write_enable_o && address_o == '0 && data_o[0]) s_cnt <= 1;
      else                                                 s_cnt <= s_cnt + 1;
   end

   always_comb begin
      data_i = '0;
      if (address_o[4:0] == 5'h00)      data_i = {63'd0, (s_cnt < hold_cyc * PERIOD)};
      else if (address_o[4:0] == 5'h0C) data_i = flags_val;
      else if (address_o[4])            data_i = sp_row(address_o[3:2], address_o[5]);
   end

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Bus monitor: every write and every sp/flags read cycle must match a queued expectation.
   always @(negedge clk) begin
      logic [AW+BW+1:0] e;
      logic [AW-1:0]    ra;
      if (write_enable_o) begin
         if (exp_wr_q.size() == 0) begin
            fail_now("unexpected_write", $sformatf("got write at %h, expected none", address_o));
         end else begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", BW'(address_o), BW'(e[AW+BW+1 -: AW]));
            chk("wr_data", data_o, e[BW+1:2]);
            chk("wr_strb", BW'(strobe_o), BW'(e[1:0]));
         end
         if (address_o == '0) begin
            ctrl_cyc = cyc;
            sp_seen = 1'b0;
         end
      end
      if (sp_read_o) begin
         if (!sp_seen) begin
            sp_seen = 1'b1;
            first_sp_cyc = cyc;
         end
         if (exp_rd_q.size() == 0) begin
            fail_now("unexpected_read", $sformatf("got read at %h, expected none", address_o));
         end else begin
            ra = exp_rd_q.pop_front();
            chk("rd_addr", BW'(address_o), BW'(ra));
         end
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, BW'(cmd_ready_o), 64'd1);
      chk({tag, "_in_ready"},  BW'(in_ready_o), 64'd0);
      chk({tag, "_addr"},      BW'(address_o), 64'd0);
      chk({tag, "_data"},      data_o, 64'd0);
      chk({tag, "_we_strb_rd"}, BW'({write_enable_o, strobe_o, sp_read_o}), 64'd0);
      chk({tag, "_out"},       BW'({out_valid_o, done_o, error_o}), 64'd0);
      chk({tag, "_out_data"},  out_data_o, 64'd0);
      chk({tag, "_flags"},     flags_o, 64'd0);
   endtask

   task automatic start_job(input int k);
      job_t j;
      logic [BW-1:0] row;
      logic [AW-1:0] wa;
      int w;
      j = jobs[k];
      hold_cyc = j.hold;
      flags_val = j.flags;
      job_tag = 8'(k);
      done_cnt = 0;
      for (int r = 0; r < 2; r++) begin
         exp_rd_q.push_back(j.exp_rd_base | (AW'(r) << 5));
         exp_rd_q.push_back(j.exp_rd_base | (AW'(r) << 5));
         exp_out_q.push_back(sp_row(j.target, r[0]));
      end
      exp_rd_q.push_back(32'h0C);
      exp_rd_q.push_back(32'h0C);
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_ctrl_i = j.ctrl;
      cmd_target_i = j.target;
      chk("cmd_ready", BW'(cmd_ready_o), 64'd1);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         row = (i < 2) ? j.a[i] : j.b[i-2];
         wa = ((i < 2) ? 32'h04 : 32'h08) | (AW'(i % 2) << 5);
         if (j.gaps && i > 0) begin
            in_valid_i = 1'b0;
            @(negedge clk);
         end
         in_valid_i = 1'b1;
         in_data_i = row;
         w = 0;
         while (!in_ready_o && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready_o) fail_now("in_ready_timeout", "in_ready_o stayed low");
         exp_wr_q.push_back({wa, row, 2'b11});
         @(negedge clk);
      end
      in_valid_i = 1'b0;
      exp_wr_q.push_back({32'h0, j.exp_ctrl, 2'b00});
   endtask

   task automatic finish_job(input int k);
      job_t j;
      logic [BW-1:0] d0;
      int w;
      j = jobs[k];
      for (int r = 0; r < 2; r++) begin
         w = 0;
         while (!out_valid_o && w < 400) begin
            @(negedge clk);
            w++;
         end
         if (!out_valid_o) begin
            fail_now("out_valid_timeout", "out_valid_o never rose");
            return;
         end
         d0 = out_data_o;
         for (int b = 0; b < j.bp; b++) begin
            @(negedge clk);
            chk("bp_stable", out_data_o, d0);
            chk("bp_hold_valid_no_read", BW'({out_valid_o, sp_read_o}), 64'd2);
         end
         out_ready_i = 1'b1;
         if (exp_out_q.size() == 0) fail_now("out_row", "no expected row queued");
         else chk("out_row", out_data_o, exp_out_q.pop_front());
         @(negedge clk);
         out_ready_i = 1'b0;
      end
      w = 0;
      while (done_cnt == 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      chk("done_count", BW'(done_cnt), 64'd1);
      chk("flags", flags_o, j.flags);
      chk("error_clear", BW'(error_o), 64'd0);
      chk("poll_timing", BW'(first_sp_cyc - ctrl_cyc), BW'(PERIOD * (j.hold + 1)));
      chk("queues_drained", BW'(exp_wr_q.size() + exp_rd_q.size() + exp_out_q.size()), 64'd0);
   endtask

   initial begin
      jobs[0] = '{a: {64'h00000004_00000003, 64'h00000002_00000001},
                  b: {64'h00000001_00000000, 64'h00000000_00000001},
                  ctrl: 16'h0000, target: 2'd0, flags: 64'h3C, hold: 3, gaps: 1'b0, bp: 0,
                  exp_ctrl: 64'h1, exp_rd_base: 32'h10};
      jobs[1] = '{a: {{$urandom, $urandom}, {$urandom, $urandom}},
                  b: {{$urandom, $urandom}, {$urandom, $urandom}},
                  ctrl: 16'h1234, target: 2'd1, flags: 64'h11, hold: 1, gaps: 1'b1, bp: 0,
                  exp_ctrl: 64'h1235, exp_rd_base: 32'h14};
      jobs[2] = '{a: {{$urandom, $urandom}, {$urandom, $urandom}},
                  b: {{$urandom, $urandom}, {$urandom, $urandom}},
                  ctrl: 16'hFFFE, target: 2'd2, flags: 64'hDEAD_BEEF_0000_0001, hold: 2,
                  gaps: 1'b0, bp: 10, exp_ctrl: 64'hFFFF, exp_rd_base: 32'h18};
      jobs[3] = '{a: {{$urandom, $urandom}, {$urandom, $urandom}},
                  b: {{$urandom, $urandom}, {$urandom, $urandom}},
                  ctrl: 16'h8001, target: 2'd3, flags: 64'hA5, hold: 0, gaps: 1'b0,
                  bp: $urandom_range(1, 4), exp_ctrl: 64'h8001, exp_rd_base: 32'h1C};

      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      check_idle_outputs("reset");

      for (int k = 0; k < NJOBS; k++) begin
         start_job(k);
         finish_job(k);
      end

      // Reset while polling: the job is abandoned and a fresh job runs cleanly.
      start_job(0);
      hold_cyc = 1000;
      repeat (3) @(negedge clk);
      chk("pre_reset_writes", BW'(exp_wr_q.size()), 64'd0);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      exp_wr_q.delete();
      exp_rd_q.delete();
      exp_out_q.delete();
      check_idle_outputs("mid_reset");
      start_job(0);
      finish_job(0);

`ifdef MATMUL_BUS_MASTER_TIMEOUT_EN
      start_job(1);
      hold_cyc = 100000;
      exp_rd_q.delete();
      exp_out_q.delete();
      begin
         int w;
         w = 0;
         while (done_cnt == 0 && w < 200) begin
            @(negedge clk);
            w++;
         end
      end
      chk("to_error", BW'(error_o), 64'd1);
      repeat (3) @(negedge clk);
      chk("to_done_count", BW'(done_cnt), 64'd1);
      chk("to_no_sp_read", BW'(sp_seen), 64'd0);
      chk("to_poll_count", BW'(done_cyc - ctrl_cyc), BW'(PL * PERIOD));
      chk("to_flags_kept", flags_o, jobs[0].flags);
      chk("to_error_held", BW'({error_o, cmd_ready_o}), 64'd3);
      start_job(2);
      finish_job(2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
